// File: rtl/pbkdf2_hmac_sched.sv
// pbkdf2_hmac_sched: arbitrates one shared HMAC-SHA256 core between the scrypt
// entry pass (A, 4 blocks over the 80-byte password as salt) and the exit pass
// (B, 1 block over the 128-byte ROMix output). Builds salt||INT(i) per block,
// gathers the T_i results into the owner's key register, and watches the core
// with an optional watchdog.
module pbkdf2_hmac_sched #(
    parameter int A_BLOCKS     = 4,
    parameter int HMAC_TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [639:0]  a_pass,
    output logic          a_gnt,
    output logic          a_done,
    output logic [1023:0] a_key,
    input  logic          b_req,
    input  logic [639:0]  b_pass,
    input  logic [1023:0] b_salt,
    output logic          b_gnt,
    output logic          b_done,
    output logic [255:0]  b_key,
    output logic          err,
    output logic          err_owner,
    output logic          hmac_start,
    output logic [639:0]  hmac_key,
    output logic [1055:0] hmac_msg,
    output logic [10:0]   hmac_msg_len,
    input  logic          hmac_done,
    input  logic [255:0]  hmac_hash
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic          r_owner;      // 0 = A, 1 = B
    logic          r_last;       // winner of the most recent tie
    logic [2:0]    r_idx;        // 1-based block index, INT(i)
    logic [15:0]   r_wdog;
    logic [639:0]  r_pass;
    logic [1023:0] r_salt;
    logic [255:0]  r_hash;
    logic          r_a_gnt;
    logic          r_b_gnt;
    logic          r_err;
    logic          r_err_owner;
    logic [255:0]  r_b_key;

    logic          w_pick_b;
    logic [2:0]    w_blocks;
    logic          w_last_blk;
    logic          w_timeout;
    logic          w_active;
    logic [31:0]   w_int;

    // B wins only when A is absent, or on a tie when A won the previous tie.
    assign w_pick_b   = b_req && (!a_req || !r_last);
    assign w_blocks   = r_owner ? 3'd1 : 3'(A_BLOCKS);
    assign w_last_blk = (r_idx == w_blocks);
    assign w_timeout  = (HMAC_TIMEOUT != 0) && (r_wdog == 16'(HMAC_TIMEOUT));
    assign w_active   = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_int      = {29'd0, r_idx};

    // Job sequencer: grant, issue each block, wait with watchdog, store, finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_idx       <= 3'd0;
            r_wdog      <= 16'd0;
            r_pass      <= '0;
            r_salt      <= '0;
            r_hash      <= '0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_err       <= 1'b0;
            r_err_owner <= 1'b0;
        end else begin
            r_a_gnt <= 1'b0;
            r_b_gnt <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (a_req || b_req) begin
                        r_owner <= w_pick_b;
                        r_pass  <= w_pick_b ? b_pass : a_pass;
                        if (w_pick_b) begin
                            r_salt <= b_salt;
                        end
                        if (a_req && b_req) begin
                            r_last <= w_pick_b;
                        end
                        r_idx   <= 3'd1;
                        r_wdog  <= 16'd0;
                        r_a_gnt <= !w_pick_b;
                        r_b_gnt <= w_pick_b;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wdog  <= 16'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (hmac_done) begin
                        r_hash  <= hmac_hash;
                        r_wdog  <= 16'd0;
                        r_state <= S_STORE;
                    end else if (w_timeout) begin
                        r_err       <= 1'b1;
                        r_err_owner <= r_owner;
                        r_wdog      <= 16'd0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                S_STORE: begin
                    if (w_last_blk) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + 3'd1;
                        r_state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // One 256-bit slot per A block; T1 lands in the most significant slot.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_slot
            logic [255:0] r_slot;
            // Capture T(gi+1) for an A job when its block is stored.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot <= '0;
                end else if ((r_state == S_STORE) && !r_owner && (r_idx == 3'(gi + 1))) begin
                    r_slot <= r_hash;
                end
            end
            assign a_key[1023 - 256*gi -: 256] = r_slot;
        end
    endgenerate

    // B has a single block, so its key is written on every B store.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_key <= '0;
        end else if ((r_state == S_STORE) && r_owner) begin
            r_b_key <= r_hash;
        end
    end

    assign b_key        = r_b_key;
    assign a_gnt        = r_a_gnt;
    assign b_gnt        = r_b_gnt;
    assign err          = r_err;
    assign err_owner    = r_err_owner;
    assign a_done       = (r_state == S_DONE) && !r_owner;
    assign b_done       = (r_state == S_DONE) && r_owner;
    assign hmac_start   = (r_state == S_ISSUE);
    // Core inputs are only presented while a block is in flight.
    assign hmac_key     = w_active ? r_pass : '0;
    assign hmac_msg     = !w_active ? '0 :
                          (r_owner ? {r_salt, w_int} : {r_pass, w_int, 384'd0});
    assign hmac_msg_len = !w_active ? 11'd0 : (r_owner ? 11'd1056 : 11'd672);

endmodule

// File: tb/tb_pbkdf2_hmac_sched.sv
// tb_pbkdf2_hmac_sched: directed bench with a behavioural HMAC core stub.
// The stub answers L cycles after each start with a hash derived from the
// message: A -> {8{32'hC0DE0000|INT}}, B -> salt[1023:768] ^ {8{INT}}.
module tb_pbkdf2_hmac_sched;
    localparam int L = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, a_req, b_req;
    logic [639:0]  a_pass, b_pass;
    logic [1023:0] b_salt;
    logic          a_gnt, a_done, b_gnt, b_done, err, err_owner, hmac_start;
    logic [1023:0] a_key;
    logic [255:0]  b_key;
    logic [639:0]  hmac_key;
    logic [1055:0] hmac_msg;
    logic [10:0]   hmac_msg_len;
    logic          hmac_done;
    logic [255:0]  hmac_hash;

    pbkdf2_hmac_sched #(.A_BLOCKS(4), .HMAC_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_pass(a_pass), .a_gnt(a_gnt), .a_done(a_done), .a_key(a_key),
        .b_req(b_req), .b_pass(b_pass), .b_salt(b_salt), .b_gnt(b_gnt), .b_done(b_done),
        .b_key(b_key), .err(err), .err_owner(err_owner),
        .hmac_start(hmac_start), .hmac_key(hmac_key), .hmac_msg(hmac_msg),
        .hmac_msg_len(hmac_msg_len), .hmac_done(hmac_done), .hmac_hash(hmac_hash)
    );

    // Stub core and event monitor
    logic          core_en = 1'b1;
    logic          busy = 1'b0;
    logic          stub_done = 1'b0;
    logic          spur_done = 1'b0;
    logic [255:0]  stub_hash = '0;
    logic [255:0]  pend_hash = '0;
    logic [255:0]  junk = {8{32'hDEADBEEF}};
    int            cnt_l = 0;
    int            cyc = 0;
    int            a_gnt_cnt = 0, b_gnt_cnt = 0, a_done_cnt = 0, b_done_cnt = 0;
    int            err_cnt = 0, start_cnt = 0, viol = 0;
    int            a_done_cyc = 0, b_gnt_cyc = 0, err_cyc = 0, start_cyc = 0;
    logic          err_owner_seen = 1'b0;
    logic [31:0]   log_int [256];
    logic [10:0]   log_len [256];
    logic [639:0]  log_key [256];
    logic [31:0]   t_int;

    assign hmac_done = stub_done | spur_done;
    assign hmac_hash = spur_done ? junk : stub_hash;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (a_gnt) a_gnt_cnt++;
        if (b_gnt) begin b_gnt_cnt++; b_gnt_cyc = cyc; end
        if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
        if (b_done) b_done_cnt++;
        if (err) begin err_cnt++; err_cyc = cyc; err_owner_seen = err_owner; end
        stub_done = 1'b0;
        if (rst) begin
            busy = 1'b0;
        end else if (hmac_start) begin
            if (busy) viol++;
            t_int = (hmac_msg_len == 11'd672) ? hmac_msg[415:384] : hmac_msg[31:0];
            log_int[start_cnt & 255] = t_int;
            log_len[start_cnt & 255] = hmac_msg_len;
            log_key[start_cnt & 255] = hmac_key;
            start_cnt++;
            start_cyc = cyc;
            pend_hash = (hmac_msg_len == 11'd672) ? {8{32'hC0DE0000 | t_int}}
                                                  : (hmac_msg[1055:800] ^ {8{t_int}});
            busy  = core_en;
            cnt_l = L;
        end else if (busy) begin
            cnt_l--;
            if (cnt_l == 0) begin
                stub_done = 1'b1;
                stub_hash = pend_hash;
                busy = 1'b0;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic int cnt_of(input int w);
        case (w)
            0: return a_gnt_cnt;
            1: return b_gnt_cnt;
            2: return a_done_cnt;
            3: return b_done_cnt;
            4: return err_cnt;
            default: return start_cnt;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int w, input int target, input int budget);
        int k = 0;
        while (cnt_of(w) < target && k < budget) begin
            step(1);
            k++;
        end
        chk({tag, " reached"}, 256'(cnt_of(w) >= target), 256'd1);
    endtask

    logic [1023:0] exp_a;
    logic [255:0]  exp_b;
    logic [639:0]  pass_a;
    logic [639:0]  pass_b;
    int            base;

    initial begin
        exp_a  = {{8{32'hC0DE0001}}, {8{32'hC0DE0002}}, {8{32'hC0DE0003}}, {8{32'hC0DE0004}}};
        exp_b  = {2{128'h00112232_44556676_8899AABA_CCDDEEFE}};
        pass_a = {80{8'h61}};
        pass_b = {80{8'h62}};
        rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
        a_pass = pass_a; b_pass = pass_b;
        b_salt = {8{128'h00112233445566778899AABBCCDDEEFF}};

        // Reset state
        step(3);
        rst = 1'b0;
        step(1);
        chk("reset a_key hi", a_key[1023:768], 256'd0);
        chk("reset b_key", b_key, 256'd0);
        chk("reset strobes", {250'd0, a_gnt, b_gnt, a_done, b_done, err, hmac_start}, 256'd0);
        chk("reset msg_len", 256'(hmac_msg_len), 256'd0);

        // A only: four blocks, INT 1..4
        a_req = 1'b1;
        wait_cnt("A gnt", 0, 1, 10);
        a_req = 1'b0;
        wait_cnt("A done", 2, 1, 300);
        step(3);
        chk("A done pulses", 256'(a_done_cnt), 256'd1);
        chk("A starts", 256'(start_cnt), 256'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("A int %0d", i + 1), 256'(log_int[i]), 256'(i + 1));
            chk($sformatf("A len %0d", i + 1), 256'(log_len[i]), 256'd672);
            chk($sformatf("A key %0d", i + 1), 256'(log_key[i] === pass_a), 256'd1);
            chk($sformatf("A slot %0d", i + 1), a_key[1023 - 256*i -: 256], exp_a[1023 - 256*i -: 256]);
        end

        // B only: one block, 1056-bit message
        base = start_cnt;
        b_req = 1'b1;
        wait_cnt("B gnt", 1, 1, 10);
        b_req = 1'b0;
        wait_cnt("B done", 3, 1, 100);
        step(3);
        chk("B done pulses", 256'(b_done_cnt), 256'd1);
        chk("B starts", 256'(start_cnt - base), 256'd1);
        chk("B len", 256'(log_len[base]), 256'd1056);
        chk("B int", 256'(log_int[base]), 256'd1);
        chk("B hmac key", 256'(log_key[base] === pass_b), 256'd1);
        chk("B key", b_key, exp_b);
        chk("A key kept", a_key[255:0], exp_a[255:0]);

        // Spurious hmac_done in IDLE
        base = start_cnt;
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        step(4);
        chk("spur idle start", 256'({hmac_start, 31'(start_cnt - base)}), 256'd0);
        chk("spur idle a_key", a_key[1023:768], exp_a[1023:768]);
        chk("spur idle b_key", b_key, exp_b);
        chk("spur idle dones", 256'(a_done_cnt + b_done_cnt), 256'd2);

        // Spurious hmac_done in ISSUE
        b_req = 1'b1;
        wait_cnt("spur B gnt", 1, 2, 10);
        b_req = 1'b0;
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        wait_cnt("spur B done", 3, 2, 100);
        chk("spur issue b_key", b_key, exp_b);
        chk("spur issue starts", 256'(start_cnt - base), 256'd1);

        // Tie from reset: A first, then B, next tie to B
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        base = a_gnt_cnt;
        a_req = 1'b1; b_req = 1'b1;
        wait_cnt("tie A gnt", 0, base + 1, 10);
        chk("tie B held", 256'(b_gnt_cnt), 256'd2);
        a_req = 1'b0;
        wait_cnt("tie B gnt", 1, 3, 300);
        chk("tie B after A", 256'(b_gnt_cyc - a_done_cyc), 256'd2);
        b_req = 1'b0;
        wait_cnt("tie B done", 3, 3, 100);
        base = a_gnt_cnt;
        a_req = 1'b1; b_req = 1'b1;
        wait_cnt("tie2 B gnt", 1, 4, 10);
        chk("tie2 A held", 256'(a_gnt_cnt), 256'(base));
        b_req = 1'b0;
        wait_cnt("tie2 A gnt", 0, base + 1, 100);
        a_req = 1'b0;
        wait_cnt("tie2 A done", 2, 3, 300);
        chk("tie A key", a_key[767:512], exp_a[767:512]);

        // Watchdog abort on a silent core
        core_en = 1'b0;
        base = a_done_cnt;
        a_req = 1'b1;
        wait_cnt("wd A gnt", 0, a_gnt_cnt + 1, 10);
        a_req = 1'b0;
        wait_cnt("wd err", 4, 1, 100);
        chk("wd err owner", 256'(err_owner_seen), 256'd0);
        chk("wd latency", 256'(err_cyc - start_cyc), 256'd18);
        step(2);
        chk("wd no done", 256'(a_done_cnt - base), 256'd0);
        chk("wd key kept", a_key[511:256], exp_a[511:256]);
        core_en = 1'b1;
        b_req = 1'b1;
        wait_cnt("wd next gnt", 1, 5, 10);
        b_req = 1'b0;
        wait_cnt("wd next done", 3, 5, 100);

        // Reset during WAIT of block 3, then a clean A job
        base = start_cnt;
        a_req = 1'b1;
        wait_cnt("mr A gnt", 0, a_gnt_cnt + 1, 10);
        a_req = 1'b0;
        wait_cnt("mr 3rd start", 5, base + 3, 200);
        step(3);
        base = a_done_cnt;
        rst = 1'b1;
        step(1);
        chk("mr a_key", a_key[1023:768], 256'd0);
        chk("mr b_key", b_key, 256'd0);
        chk("mr outputs", {245'd0, a_gnt, b_gnt, a_done, b_done, err, err_owner, hmac_start,
                           (hmac_msg_len == 11'd0), (hmac_key == 640'd0), (hmac_msg == 1056'd0)},
            256'd7);
        rst = 1'b0;
        step(30);
        chk("mr no done/err", 256'(a_done_cnt - base + err_cnt), 256'd1);
        a_req = 1'b1;
        wait_cnt("mr2 A gnt", 0, a_gnt_cnt + 1, 10);
        a_req = 1'b0;
        wait_cnt("mr2 A done", 2, base + 1, 300);
        chk("mr2 slot1", a_key[1023:768], exp_a[1023:768]);
        chk("mr2 slot4", a_key[255:0], exp_a[255:0]);
        chk("start while busy", 256'(viol), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
